dm_mmio_responder: RTL and testbench

//  Memory-mapped peripheral acting as a responder on the CPU data-memory port (CS/OE/WEB/A/DI/DO),

---
 rtl/dm_mmio_responder.sv | 156 +++++++++++++++
 tb/tb_dm_mmio_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_mmio_responder.sv
// Data-memory-port responder: control/status, countdown timer with irq, scratch register and a TX FIFO.
// Access timing matches the data SRAM: writes take effect at the edge, reads appear on DO one cycle later.
module dm_mmio_responder #(
    parameter int FIFO_DEPTH = 8,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CS,
    input  logic          OE,
    input  logic [3:0]    WEB,
    input  logic [13:0]   A,
    input  logic [DW-1:0] DI,
    output logic [DW-1:0] DO,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [2:0]    ctrl_q, ctrl_d;
    logic          expired_q, expired_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] load_q, load_d;
    logic [DW-1:0] val_q, val_d;
    logic [DW-1:0] scratch_q, scratch_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          irq_q, irq_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [FIFO_DEPTH];

    logic [DW-1:0] wmask;
    logic [DW-1:0] status;
    logic [DW-1:0] rd_val;
    logic          acc_rd, acc_wr;
    logic          empty, full;
    logic          push, pop, push_ok;
    logic          exp_set, exp_clr, ovf_set, ovf_clr;
    logic [DW-1:0] ctrl_merged;

    assign DO       = OE ? rdata_q : '0;
    assign tx_data  = mem_q[rptr_q];
    assign tx_valid = ~empty;
    assign irq      = irq_q;

    always_comb begin
        wmask       = {{8{~WEB[3]}}, {8{~WEB[2]}}, {8{~WEB[1]}}, {8{~WEB[0]}}};
        acc_rd      = CS & (WEB == 4'hF);
        acc_wr      = CS & (WEB != 4'hF);
        empty       = (count_q == '0);
        full        = (count_q == FULL_CNT);
        ctrl_merged = ({{(DW-3){1'b0}}, ctrl_q} & ~wmask) | (DI & wmask);

        status      = '0;
        status[0]   = empty;
        status[1]   = full;
        status[2]   = expired_q;
        status[3]   = overflow_q;
        status[8 +: CW] = count_q;

        case (A[2:0])
            3'd0:    rd_val = {{(DW-3){1'b0}}, ctrl_q};
            3'd1:    rd_val = status;
            3'd2:    rd_val = load_q;
            3'd3:    rd_val = val_q;
            3'd4:    rd_val = empty ? '0 : mem_q[rptr_q];
            3'd5:    rd_val = scratch_q;
            default: rd_val = '0;
        endcase

        ctrl_d    = ctrl_q;
        load_d    = load_q;
        val_d     = val_q;
        scratch_d = scratch_q;
        rdata_d   = acc_rd ? rd_val : rdata_q;
        exp_set   = 1'b0;
        exp_clr   = 1'b0;
        ovf_clr   = 1'b0;
        push      = 1'b0;

        if (ctrl_q[0]) begin
            if (val_q != '0) begin
                val_d = val_q - 1'b1;
            end else begin
                exp_set = 1'b1;
                if (ctrl_q[1]) val_d = load_q;
                else           ctrl_d[0] = 1'b0;
            end
        end

        // Software writes come after the timer so a LOAD or CTRL write overrides it.
        if (acc_wr) begin
            case (A[2:0])
                3'd0: ctrl_d = ctrl_merged[2:0];
                3'd1: begin
                    exp_clr = ~WEB[0] & DI[2];
                    ovf_clr = ~WEB[0] & DI[3];
                end
                3'd2: begin
                    load_d = (load_q & ~wmask) | (DI & wmask);
                    val_d  = (load_q & ~wmask) | (DI & wmask);
                end
                3'd4:    push      = 1'b1;
                3'd5:    scratch_d = (scratch_q & ~wmask) | (DI & wmask);
                default: ;
            endcase
        end

        pop     = tx_valid & tx_ready;
        push_ok = push & (~full | pop);
        ovf_set = push & full & ~pop;

        expired_d  = exp_set | (expired_q & ~exp_clr);
        overflow_d = ovf_set | (overflow_q & ~ovf_clr);
        irq_d      = expired_q & ctrl_q[2];

        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            expired_q  <= 1'b0;
            overflow_q <= 1'b0;
            load_q     <= '0;
            val_q      <= '0;
            scratch_q  <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            expired_q  <= expired_d;
            overflow_q <= overflow_d;
            load_q     <= load_d;
            val_q      <= val_d;
            scratch_q  <= scratch_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            if (push_ok) mem_q[wptr_q] <= DI & wmask;
        end
    end
endmodule

// File: tb/tb_dm_mmio_responder.sv
// Bench for dm_mmio_responder: directed scenarios plus a randomized run against a queue-based model.
module tb_dm_mmio_responder;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, CS, OE, tx_ready;
    logic [3:0]  WEB;
    logic [13:0] A;
    logic [31:0] DI, DO, tx_data;
    logic        tx_valid, irq;

    int n_pass = 0;
    int n_total = 0;

    // Reference state kept at register-map level; the FIFO is a plain queue.
    logic [2:0]  m_ctrl;
    logic        m_exp, m_ovf, m_irq;
    logic [31:0] m_load, m_val, m_scr, m_rd;
    logic [31:0] m_q[$];

    dm_mmio_responder #(.FIFO_DEPTH(DEPTH), .DW(32)) dut (
        .clk(clk), .rst(rst), .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [2:0] sel);
        logic [31:0] r;
        r = 32'h0;
        case (sel)
            3'd0: r = {29'h0, m_ctrl};
            3'd1: r = (m_q.size() == 0 ? 32'h1 : 32'h0) | (m_q.size() == DEPTH ? 32'h2 : 32'h0)
                      | (m_exp ? 32'h4 : 32'h0) | (m_ovf ? 32'h8 : 32'h0) | (m_q.size() << 8);
            3'd2: r = m_load;
            3'd3: r = m_val;
            3'd4: r = (m_q.size() == 0) ? 32'h0 : m_q[0];
            3'd5: r = m_scr;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_step(input logic r, input logic c, input logic [3:0] w,
                              input logic [13:0] a, input logic [31:0] d, input logic rdy);
        logic [31:0] mask, merged_ctrl;
        logic [2:0]  ctrl_n;
        logic [31:0] val_n, load_n, scr_n;
        logic        exp_set, ovf_set, exp_clr, ovf_clr, irq_n, wr;
        if (r) begin
            m_ctrl = 0; m_exp = 0; m_ovf = 0; m_irq = 0;
            m_load = 0; m_val = 0; m_scr = 0; m_rd = 0;
            m_q.delete();
            return;
        end
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (!w[b]) mask[b*8 +: 8] = 8'hFF;
        wr = c && (w != 4'hF);
        if (c && w == 4'hF) m_rd = model_read(a[2:0]);
        irq_n = m_exp & m_ctrl[2];
        ctrl_n = m_ctrl; val_n = m_val; load_n = m_load; scr_n = m_scr;
        exp_set = 0; ovf_set = 0; exp_clr = 0; ovf_clr = 0;
        if (m_ctrl[0]) begin
            if (m_val != 0) val_n = m_val - 1;
            else begin
                exp_set = 1;
                if (m_ctrl[1]) val_n = m_load; else ctrl_n[0] = 0;
            end
        end
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (wr) begin
            case (a[2:0])
                3'd0: begin
                    merged_ctrl = ({29'h0, m_ctrl} & ~mask) | (d & mask);
                    ctrl_n = merged_ctrl[2:0];
                end
                3'd1: begin
                    exp_clr = !w[0] && d[2];
                    ovf_clr = !w[0] && d[3];
                end
                3'd2: begin
                    load_n = (m_load & ~mask) | (d & mask);
                    val_n = load_n;
                end
                3'd4: if (m_q.size() < DEPTH) m_q.push_back(d & mask); else ovf_set = 1;
                3'd5: scr_n = (m_scr & ~mask) | (d & mask);
                default: ;
            endcase
        end
        m_exp = exp_set ? 1'b1 : (exp_clr ? 1'b0 : m_exp);
        m_ovf = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        m_ctrl = ctrl_n; m_val = val_n; m_load = load_n; m_scr = scr_n; m_irq = irq_n;
    endtask

    task automatic cyc(input logic r, input logic c, input logic [3:0] w,
                       input logic [13:0] a, input logic [31:0] d, input logic rdy);
        rst = r; CS = c; WEB = w; A = a; DI = d; tx_ready = rdy;
        model_step(r, c, w, a, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [3:0] w, input logic [31:0] d, input logic rdy);
        cyc(0, 1, w, a, d, rdy);
    endtask

    task automatic rd(input logic [13:0] a, input logic rdy);
        cyc(0, 1, 4'hF, a, 32'h0, rdy);
    endtask

    task automatic test_reset;
        OE = 1;
        cyc(1, 1, 4'hF, 14'd1, 32'h0, 0);
        cyc(1, 1, 4'hF, 14'd1, 32'h0, 0);
        n_total++; if (DO !== 32'h0) $display("FAIL reset_do got=%h exp=0", DO); else n_pass++;
        n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else n_pass++;
        rd(14'd1, 0);
        n_total++; if (DO !== 32'h1) $display("FAIL reset_status got=%h exp=00000001", DO); else n_pass++;
    endtask

    task automatic test_byte_write;
        wr(14'd5, 4'h0, 32'hAABBCCDD, 0);
        wr(14'd5, 4'b1101, 32'h00001100, 0);
        rd(14'd5, 0);
        n_total++; if (DO !== 32'hAABB11DD) $display("FAIL byte_write got=%h exp=aabb11dd", DO); else n_pass++;
        OE = 0; #1;
        n_total++; if (DO !== 32'h0) $display("FAIL oe_gate got=%h exp=0", DO); else n_pass++;
        OE = 1; #1;
        rd(14'h3FF5, 0);
        n_total++; if (DO !== 32'hAABB11DD) $display("FAIL addr_alias got=%h exp=aabb11dd", DO); else n_pass++;
    endtask

    task automatic test_timer;
        logic [31:0] exp_seq [5];
        int guard;
        exp_seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
        wr(14'd2, 4'h0, 32'd3, 0);
        wr(14'd0, 4'h0, 32'h7, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                n_total++; if (irq !== 1'b0) $display("FAIL irq_lag got=%b exp=0", irq); else n_pass++;
            end
            rd(14'd3, 0);
            n_total++;
            if (DO !== exp_seq[i]) $display("FAIL tmr_val[%0d] got=%0d exp=%0d", i, DO, exp_seq[i]);
            else n_pass++;
        end
        n_total++; if (irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq); else n_pass++;
        rd(14'd1, 0);
        n_total++; if (DO[2] !== 1'b1) $display("FAIL expired_set got=%b exp=1", DO[2]); else n_pass++;
        guard = 0;
        while (!(m_ctrl[0] && m_val == 0) && guard < 20) begin
            cyc(0, 0, 4'hF, 14'd0, 32'h0, 0);
            guard++;
        end
        n_total++; if (guard >= 20) $display("FAIL expiry_wait got=timeout exp=expiry"); else n_pass++;
        wr(14'd1, 4'h0, 32'h4, 0);
        rd(14'd1, 0);
        n_total++; if (DO[2] !== 1'b1) $display("FAIL w1c_vs_set got=%b exp=1", DO[2]); else n_pass++;
        wr(14'd0, 4'h0, 32'h0, 0);
        wr(14'd1, 4'h0, 32'h4, 0);
        rd(14'd1, 0);
        n_total++; if (DO[2] !== 1'b0) $display("FAIL w1c_clear got=%b exp=0", DO[2]); else n_pass++;
    endtask

    task automatic test_fifo_fill;
        for (int i = 1; i <= 9; i++) wr(14'd4, 4'h0, i, 0);
        rd(14'd1, 0);
        n_total++; if (DO !== 32'h80A) $display("FAIL fill_status got=%h exp=0000080a", DO); else n_pass++;
        n_total++; if (tx_data !== 32'd1) $display("FAIL fill_head got=%h exp=1", tx_data); else n_pass++;
        rd(14'd4, 0);
        n_total++; if (DO !== 32'd1) $display("FAIL peek got=%h exp=1", DO); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            n_total++;
            if (tx_valid !== 1'b1 || tx_data !== i) $display("FAIL drain[%0d] got=%b/%h exp=1/%h", i, tx_valid, tx_data, i);
            else n_pass++;
            cyc(0, 0, 4'hF, 14'd0, 32'h0, 1);
        end
        n_total++; if (tx_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", tx_valid); else n_pass++;
        rd(14'd4, 0);
        n_total++; if (DO !== 32'h0) $display("FAIL peek_empty got=%h exp=0", DO); else n_pass++;
    endtask

    task automatic test_full_pushpop;
        logic [31:0] exp_w [8];
        wr(14'd1, 4'h0, 32'h8, 0);
        for (int i = 0; i < 8; i++) wr(14'd4, 4'h0, 32'h100 + i, 0);
        wr(14'd4, 4'h0, 32'h55, 1);
        rd(14'd1, 0);
        n_total++; if (DO !== 32'h802) $display("FAIL pushpop_status got=%h exp=00000802", DO); else n_pass++;
        for (int i = 0; i < 7; i++) exp_w[i] = 32'h101 + i;
        exp_w[7] = 32'h55;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (tx_data !== exp_w[i]) $display("FAIL pushpop_order[%0d] got=%h exp=%h", i, tx_data, exp_w[i]);
            else n_pass++;
            cyc(0, 0, 4'hF, 14'd0, 32'h0, 1);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) wr(14'd4, 4'h0, 32'hA0 + i, 0);
        wr(14'd2, 4'h0, 32'd20, 0);
        wr(14'd0, 4'h0, 32'h1, 0);
        cyc(0, 0, 4'hF, 14'd0, 32'h0, 1);
        cyc(1, 0, 4'hF, 14'd0, 32'h0, 1);
        n_total++; if (tx_valid !== 1'b0) $display("FAIL mid_reset_valid got=%b exp=0", tx_valid); else n_pass++;
        rd(14'd3, 0);
        n_total++; if (DO !== 32'h0) $display("FAIL mid_reset_val got=%h exp=0", DO); else n_pass++;
        rd(14'd0, 0);
        n_total++; if (DO !== 32'h0) $display("FAIL mid_reset_ctrl got=%h exp=0", DO); else n_pass++;
    endtask

    task automatic test_random;
        logic        c, rdy, r;
        logic [3:0]  w;
        logic [13:0] a;
        logic [31:0] d;
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            c   = ($urandom_range(0, 3) != 0);
            w   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            a   = 14'($urandom);
            d   = $urandom;
            if (a[2:0] == 3'd2) d = $urandom_range(0, 6);
            rdy = ($urandom_range(0, 2) == 0);
            cyc(r, c, w, a, d, rdy);
            n_total++;
            if (DO !== m_rd) $display("FAIL rand_do[%0d] got=%h exp=%h", n, DO, m_rd); else n_pass++;
            n_total++;
            if (tx_valid !== (m_q.size() != 0)) $display("FAIL rand_valid[%0d] got=%b exp=%b", n, tx_valid, m_q.size() != 0);
            else n_pass++;
            if (m_q.size() != 0) begin
                n_total++;
                if (tx_data !== m_q[0]) $display("FAIL rand_head[%0d] got=%h exp=%h", n, tx_data, m_q[0]); else n_pass++;
            end
            n_total++;
            if (irq !== m_irq) $display("FAIL rand_irq[%0d] got=%b exp=%b", n, irq, m_irq); else n_pass++;
        end
    endtask

    initial begin
        rst = 1; CS = 0; OE = 1; WEB = 4'hF; A = 0; DI = 0; tx_ready = 0;
        test_reset;
        test_byte_write;
        test_timer;
        test_fifo_fill;
        test_full_pushpop;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
